// File: rtl/store_diffusion_errors_if.sv
// Bus bundle between the UV DC correction stage and the diffusion-error store.
// The correction stage drives the master side; the store implements the slave side.
interface store_diffusion_errors_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              frame_start;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] x;
    logic [47:0]       derr;
    logic              top_derr_en;
    logic [ADDR_W-1:0] top_derr_addr;
    logic [31:0]       top_derr;
    logic [31:0]       left_derr;
    logic              ovf;

    modport master (
        output frame_start, wr_valid, x, derr, top_derr_en, top_derr_addr,
        input  wr_ready, top_derr, left_derr, ovf
    );

    modport slave (
        input  frame_start, wr_valid, x, derr, top_derr_en, top_derr_addr,
        output wr_ready, top_derr, left_derr, ovf
    );
endinterface

// File: rtl/store_diffusion_errors.sv
// Chroma DC error-diffusion store: splits err3 into 3/4 left and 1/4 top, keeps the left
// word in a register and per-column top words in a RAM masked by per-column valid bits.
module store_diffusion_errors #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    store_diffusion_errors_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] x_q, x_d;
    logic [47:0]       derr_q, derr_d;
    logic [31:0]       left_q, left_d;
    logic [31:0]       top_derr_q, top_derr_d;
    logic              ovf_q, ovf_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [31:0]       ram_q [DEPTH];
    logic              ram_we;

    // Returns {top1, top0, left1, left0} for one channel packed as {e3, e2, e1}.
    function automatic logic [31:0] split_chan(input logic [23:0] e);
        logic signed [9:0] prod;
        logic [7:0]        l1;
        logic signed [8:0] diff;
        prod = $signed({{2{e[23]}}, e[23:16]}) * 10'sd3;
        l1   = 8'(prod >>> 2);
        diff = $signed({e[23], e[23:16]}) - $signed({l1[7], l1});
        return {diff[7:0], e[15:8], l1, e[7:0]};
    endfunction

    logic [31:0]       u_split, v_split;
    logic [31:0]       left_word, top_word;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range;

    always_comb begin
        u_split     = split_chan(derr_q[23:0]);
        v_split     = split_chan(derr_q[47:24]);
        left_word   = {v_split[15:0], u_split[15:0]};
        top_word    = {v_split[31:16], u_split[31:16]};
        wr_idx      = IDX_W'(x_q);
        rd_idx      = IDX_W'(bus.top_derr_addr);
        wr_in_range = {1'b0, x_q} < DEPTH_L;
        rd_in_range = {1'b0, bus.top_derr_addr} < DEPTH_L;
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        derr_d     = derr_q;
        left_d     = left_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        top_derr_d = top_derr_q;
        ram_we     = 1'b0;

        // Clear first so a coinciding or in-flight write still lands afterwards.
        if (bus.frame_start) begin
            left_d  = '0;
            valid_d = '0;
            ovf_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.wr_valid) begin
                    x_d     = bus.x;
                    derr_d  = bus.derr;
                    state_d = CALC;
                end
            end
            CALC: begin
                left_d  = left_word;
                state_d = WRITE;
            end
            WRITE: begin
                if (wr_in_range) begin
                    valid_d[wr_idx] = 1'b1;
                    ram_we          = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.wr_valid && (state_q != IDLE)) begin
            ovf_d = 1'b1;
        end

        // Bypass ranks above the valid mask so a first write to a column is readable at once.
        if (bus.top_derr_en) begin
            if (bus.frame_start || !rd_in_range) begin
                top_derr_d = '0;
            end else if ((state_q == WRITE) && (x_q == bus.top_derr_addr)) begin
                top_derr_d = top_word;
            end else if (valid_q[rd_idx]) begin
                top_derr_d = ram_q[rd_idx];
            end else begin
                top_derr_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            derr_q     <= '0;
            left_q     <= '0;
            top_derr_q <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            derr_q     <= derr_d;
            left_q     <= left_d;
            top_derr_q <= top_derr_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    // Storage is not reset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram_q[wr_idx] <= top_word;
        end
    end

    assign bus.wr_ready  = (state_q == IDLE);
    assign bus.top_derr  = top_derr_q;
    assign bus.left_derr = left_q;
    assign bus.ovf       = ovf_q;
endmodule
